// File: rtl/riscv_mem_pkg.sv
// Shared types and defaults for the main-memory controller.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } mem_state_t;

    typedef enum logic {
        CLIENT_IC,
        CLIENT_DC
    } mem_client_t;

    localparam int unsigned DEF_LINE_WIDTH = 128;
    localparam int unsigned DEF_MEM_LINES  = 4096;

endpackage

// File: rtl/riscv_mem_rr_arbiter.sv
// Two-way round-robin arbiter between the instruction and data cache clients.
// grant[0] = IC, grant[1] = DC. last_grant only moves when a grant is taken.
module riscv_mem_rr_arbiter
    import riscv_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ic_req,
    input  logic       dc_req,
    input  logic       grant_en,
    output logic [1:0] grant
);

    mem_client_t last_grant;

    // On a tie the client that did not win last time is chosen
    always_comb begin
        grant = 2'b00;
        if (ic_req && dc_req) begin
            grant = (last_grant == CLIENT_IC) ? 2'b10 : 2'b01;
        end else if (dc_req) begin
            grant = 2'b10;
        end else if (ic_req) begin
            grant = 2'b01;
        end
    end

    // Remember the winner of each accepted grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= CLIENT_IC;
        end else if (grant_en && (grant != 2'b00)) begin
            last_grant <= grant[1] ? CLIENT_DC : CLIENT_IC;
        end
    end

endmodule

// File: rtl/riscv_main_mem_ctrl.sv
// Line-organised main memory shared by the instruction and data caches.
// Serves one transaction at a time with a fixed BUSY latency and returns
// whole lines with a single-cycle ready pulse to the granted client.
module riscv_main_mem_ctrl
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int unsigned MEM_LINES  = DEF_MEM_LINES,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                  i_riscv_mem_clk,
    input  logic                  i_riscv_mem_rst,
    input  logic                  i_riscv_mem_ic_req,
    input  logic [ADDR_WIDTH-1:0] i_riscv_mem_ic_addr,
    output logic                  o_riscv_mem_ic_ready,
    output logic [LINE_WIDTH-1:0] o_riscv_mem_ic_rdata,
    input  logic                  i_riscv_mem_dc_req,
    input  logic                  i_riscv_mem_dc_we,
    input  logic [ADDR_WIDTH-1:0] i_riscv_mem_dc_addr,
    input  logic [LINE_WIDTH-1:0] i_riscv_mem_dc_wdata,
    output logic                  o_riscv_mem_dc_ready,
    output logic [LINE_WIDTH-1:0] o_riscv_mem_dc_rdata
);

    localparam int unsigned LINE_BYTES = LINE_WIDTH / 8;
    localparam int unsigned OFF_BITS   = $clog2(LINE_BYTES);
    localparam int unsigned IDX_BITS   = $clog2(MEM_LINES);

    logic [LINE_WIDTH-1:0] mem_array [MEM_LINES];

    mem_state_t            state;
    logic [7:0]            cnt;
    mem_client_t           gnt_client;
    logic [IDX_BITS-1:0]   line_idx;
    logic                  txn_we;
    logic [LINE_WIDTH-1:0] txn_wdata;

    logic [1:0]            grant;
    logic                  grant_en;
    logic                  last_step;
    logic                  mem_write;
    logic [IDX_BITS-1:0]   ic_idx;
    logic [IDX_BITS-1:0]   dc_idx;

    // Offset and upper address bits are deliberately ignored (lines alias)
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_riscv_mem_ic_addr, i_riscv_mem_dc_addr};

    assign ic_idx    = i_riscv_mem_ic_addr[OFF_BITS +: IDX_BITS];
    assign dc_idx    = i_riscv_mem_dc_addr[OFF_BITS +: IDX_BITS];
    assign grant_en  = (state == IDLE);
    assign last_step = (cnt == 8'(LATENCY - 1));
    assign mem_write = (state == BUSY) && last_step && txn_we;

    riscv_mem_rr_arbiter u_arbiter (
        .clk      (i_riscv_mem_clk),
        .rst_n    (i_riscv_mem_rst),
        .ic_req   (i_riscv_mem_ic_req),
        .dc_req   (i_riscv_mem_dc_req),
        .grant_en (grant_en),
        .grant    (grant)
    );

    // Array write port; contents survive reset, uncommitted writes are lost
    always_ff @(posedge i_riscv_mem_clk) begin
        if (mem_write) begin
            mem_array[line_idx] <= txn_wdata;
        end
    end

    // Transaction FSM: grant and latch in IDLE, count in BUSY, pulse ready in RESP
    always_ff @(posedge i_riscv_mem_clk or negedge i_riscv_mem_rst) begin
        if (!i_riscv_mem_rst) begin
            state                <= IDLE;
            cnt                  <= 8'd0;
            gnt_client           <= CLIENT_IC;
            line_idx             <= '0;
            txn_we               <= 1'b0;
            txn_wdata            <= '0;
            o_riscv_mem_ic_ready <= 1'b0;
            o_riscv_mem_dc_ready <= 1'b0;
            o_riscv_mem_ic_rdata <= '0;
            o_riscv_mem_dc_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        gnt_client <= grant[1] ? CLIENT_DC : CLIENT_IC;
                        line_idx   <= grant[1] ? dc_idx : ic_idx;
                        // IC is read-only, so a write can only come from DC
                        txn_we     <= grant[1] & i_riscv_mem_dc_we;
                        txn_wdata  <= i_riscv_mem_dc_wdata;
                        cnt        <= 8'd0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (last_step) begin
                        if (!txn_we) begin
                            if (gnt_client == CLIENT_DC) begin
                                o_riscv_mem_dc_rdata <= mem_array[line_idx];
                            end else begin
                                o_riscv_mem_ic_rdata <= mem_array[line_idx];
                            end
                        end
                        o_riscv_mem_ic_ready <= (gnt_client == CLIENT_IC);
                        o_riscv_mem_dc_ready <= (gnt_client == CLIENT_DC);
                        state                <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    o_riscv_mem_ic_ready <= 1'b0;
                    o_riscv_mem_dc_ready <= 1'b0;
                    state                <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_main_mem_ctrl.sv
// Scoreboard bench for riscv_main_mem_ctrl: stimulus pushes expected responses,
// a monitor pops and checks them on every ready pulse.
module tb_riscv_main_mem_ctrl;
    import riscv_mem_pkg::*;

    localparam int unsigned AW  = 64;
    localparam int unsigned LW  = 128;
    localparam int unsigned ML  = 4096;
    localparam int unsigned LAT = 4;

    localparam logic [LW-1:0] PRE   = 128'h0123456789ABCDEF_0123456789ABCDEF;
    localparam logic [LW-1:0] OLD   = 128'h0C0C0C0C_11112222_33334444_0C0C0C0C;
    localparam logic [LW-1:0] NEW   = 128'hFEEDFACE_FEEDFACE_FEEDFACE_FEEDFACE;
    localparam logic [LW-1:0] DB    = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    localparam logic [LW-1:0] ALIAS = 128'hA11A5A11_A5A11A5A_11A5A11A_5A11A5A1;
    localparam logic [LW-1:0] JUNK  = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ic_req = 1'b0;
    logic [AW-1:0] ic_addr = '0;
    logic          ic_ready;
    logic [LW-1:0] ic_rdata;
    logic          dc_req = 1'b0;
    logic          dc_we = 1'b0;
    logic [AW-1:0] dc_addr = '0;
    logic [LW-1:0] dc_wdata = '0;
    logic          dc_ready;
    logic [LW-1:0] dc_rdata;

    riscv_main_mem_ctrl #(
        .ADDR_WIDTH (AW),
        .LINE_WIDTH (LW),
        .MEM_LINES  (ML),
        .LATENCY    (LAT)
    ) dut (
        .i_riscv_mem_clk      (clk),
        .i_riscv_mem_rst      (rst_n),
        .i_riscv_mem_ic_req   (ic_req),
        .i_riscv_mem_ic_addr  (ic_addr),
        .o_riscv_mem_ic_ready (ic_ready),
        .o_riscv_mem_ic_rdata (ic_rdata),
        .i_riscv_mem_dc_req   (dc_req),
        .i_riscv_mem_dc_we    (dc_we),
        .i_riscv_mem_dc_addr  (dc_addr),
        .i_riscv_mem_dc_wdata (dc_wdata),
        .o_riscv_mem_dc_ready (dc_ready),
        .o_riscv_mem_dc_rdata (dc_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit            is_dc;
        bit            chk_data;
        logic [LW-1:0] data;
        int            at;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   fails  = 0;
    int   pulses = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_rsp(input bit is_dc, input bit chk, input logic [LW-1:0] d, input int at);
        exp_t e;
        e.is_dc    = is_dc;
        e.chk_data = chk;
        e.data     = d;
        e.at       = at;
        sb.push_back(e);
    endtask

    // Bounded wait for this client's ready, sampled on the falling edge
    task automatic wait_ready(input bit is_dc);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = is_dc ? dc_ready : ic_ready;
        end
        if (!seen) check("ready timeout", LW'(0), LW'(1));
    endtask

    task automatic ic_txn(input logic [AW-1:0] a);
        ic_addr = a;
        ic_req  = 1'b1;
        wait_ready(1'b0);
        @(posedge clk);
        #1 ic_req = 1'b0;
    endtask

    task automatic dc_txn(input bit we, input logic [AW-1:0] a, input logic [LW-1:0] wd);
        dc_we    = we;
        dc_addr  = a;
        dc_wdata = wd;
        dc_req   = 1'b1;
        wait_ready(1'b1);
        @(posedge clk);
        #1 dc_req = 1'b0;
    endtask

    task automatic rd_ic(input logic [AW-1:0] a, input logic [LW-1:0] exp);
        expect_rsp(1'b0, 1'b1, exp, cyc + LAT + 1);
        ic_txn(a);
    endtask

    task automatic rd_dc(input logic [AW-1:0] a, input logic [LW-1:0] exp);
        expect_rsp(1'b1, 1'b1, exp, cyc + LAT + 1);
        dc_txn(1'b0, a, '0);
    endtask

    task automatic wr_dc(input logic [AW-1:0] a, input logic [LW-1:0] d);
        expect_rsp(1'b1, 1'b0, '0, cyc + LAT + 1);
        dc_txn(1'b1, a, d);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (ic_ready || dc_ready) begin
                pulses++;
                if (sb.size() == 0) begin
                    check("unexpected ready", LW'({ic_ready, dc_ready}), LW'(0));
                end else begin
                    e = sb.pop_front();
                    check("ready client", LW'({ic_ready, dc_ready}),
                          e.is_dc ? LW'(2'b01) : LW'(2'b10));
                    check("ready cycle", LW'(cyc), LW'(e.at));
                    if (e.chk_data) begin
                        check("rdata", e.is_dc ? dc_rdata : ic_rdata, e.data);
                    end
                end
            end
        end
    endtask

    task automatic simultaneous_round();
        int t;
        t = cyc;
        expect_rsp(1'b1, 1'b1, PRE, t + LAT + 1);
        expect_rsp(1'b0, 1'b1, DB, t + 2 * LAT + 3);
        fork
            dc_txn(1'b0, 64'h40, '0);
            ic_txn(64'h80);
        join
    endtask

    task automatic stimulus();
        int t;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset ic_ready", LW'(ic_ready), LW'(0));
        check("reset dc_ready", LW'(dc_ready), LW'(0));
        check("reset ic_rdata", ic_rdata, '0);
        check("reset dc_rdata", dc_rdata, '0);
        check("reset state", LW'(dut.state), LW'(IDLE));
        rst_n = 1'b1;

        // Preload, then IC fill of line 4
        wr_dc(64'h40, PRE);
        wr_dc(64'hC0, OLD);
        rd_ic(64'h40, PRE);

        // Writeback followed by reads from both clients
        wr_dc(64'h80, DB);
        rd_dc(64'h80, DB);
        rd_ic(64'h80, DB);

        // Ties twice: DC, IC, DC, IC
        simultaneous_round();
        simultaneous_round();

        // Aliasing and offset bits; writeback leaves dc_rdata alone
        wr_dc(64'h10, ALIAS);
        check("dc_rdata held over write", dc_rdata, PRE);
        rd_ic(64'h10 + 64'(ML * 16), ALIAS);
        rd_dc(64'h1F, ALIAS);

        // Async reset during BUSY cnt=1 of a writeback
        dc_we    = 1'b1;
        dc_addr  = 64'hC0;
        dc_wdata = NEW;
        dc_req   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("cnt before reset", LW'(dut.cnt), LW'(1));
        rst_n = 1'b0;
        #1;
        check("mid reset ic_ready", LW'(ic_ready), LW'(0));
        check("mid reset dc_ready", LW'(dc_ready), LW'(0));
        check("mid reset ic_rdata", ic_rdata, '0);
        check("mid reset dc_rdata", dc_rdata, '0);
        check("mid reset state", LW'(dut.state), LW'(IDLE));
        dc_req = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        rd_dc(64'hC0, OLD);

        // Inputs change after grant; response follows the latched address
        t = cyc;
        expect_rsp(1'b1, 1'b1, DB, t + LAT + 1);
        fork
            dc_txn(1'b0, 64'h80, '0);
            begin
                @(posedge clk);
                @(posedge clk);
                #2;
                dc_addr  = 64'h40;
                dc_we    = 1'b1;
                dc_wdata = JUNK;
            end
        join
        repeat (12) @(posedge clk);
        #1;
        check("ready pulse count", LW'(pulses), LW'(15));
        check("scoreboard drained", LW'(sb.size()), LW'(0));
        rd_ic(64'h40, PRE);
        repeat (3) @(posedge clk);
        check("scoreboard drained at end", LW'(sb.size()), LW'(0));
    endtask

    initial begin
        fork
            monitor();
            begin
                stimulus();
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
        join
    end

endmodule
